// File: rtl/uart_rx_aux.sv
`default_nettype none
// =============================================================================
// uart_rx_aux : 16x oversampled UART receiver (start + 8 data LSB first +
//               parity + stop) for the debug/load link.   Rev 1.0
// =============================================================================
module uart_rx_aux #(
  parameter int N_BITS_DATA  = 8,
  parameter int N_CONT_TICKS = 4,
  parameter int N_BITS_STATE = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   s_ticks,
  input  logic                   rx_data_in,
  output logic [N_BITS_DATA-1:0] rx_data_out,
  output logic                   rx_done_o,
  output logic                   parity_err_o,
  output logic                   frame_err_o
);

  localparam int COUNT_READ_DATA = 16;
  localparam logic [N_CONT_TICKS-1:0] TICK_MID  = N_CONT_TICKS'(COUNT_READ_DATA / 2 - 1);
  localparam logic [N_CONT_TICKS-1:0] TICK_LAST = N_CONT_TICKS'(COUNT_READ_DATA - 1);
  localparam logic [N_CONT_TICKS-1:0] BIT_LAST  = N_CONT_TICKS'(N_BITS_DATA - 1);

  typedef enum logic [N_BITS_STATE-1:0] {
    IDLE   = N_BITS_STATE'(1),
    START  = N_BITS_STATE'(2),
    DATA   = N_BITS_STATE'(4),
    PARITY = N_BITS_STATE'(8),
    STOP   = N_BITS_STATE'(16)
  } state_t;

  state_t                  state;
  logic                    sync1;
  logic                    rxs;
  logic [N_CONT_TICKS-1:0] tick_cnt;
  logic [N_CONT_TICKS-1:0] bit_cnt;
  logic [N_BITS_DATA-1:0]  shreg;
  logic                    parity_pend;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1        <= 1'b1;
      rxs          <= 1'b1;
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      parity_pend  <= 1'b0;
      rx_data_out  <= '0;
      rx_done_o    <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      sync1     <= rx_data_in;
      rxs       <= sync1;
      rx_done_o <= 1'b0;
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (s_ticks) begin
            if (tick_cnt == TICK_MID) begin
              // Mid start bit: a line that is high again was only a glitch
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rxs ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_ticks) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == TICK_LAST) begin
              shreg   <= {rxs, shreg[N_BITS_DATA-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) state <= PARITY;
            end
          end
        end
        PARITY: begin
          if (s_ticks) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == TICK_LAST) begin
              parity_pend <= rxs;
              state       <= STOP;
            end
          end
        end
        STOP: begin
          if (s_ticks) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == TICK_LAST) begin
              // Leave mid stop bit so a back-to-back start edge is not missed
              state        <= IDLE;
              tick_cnt     <= '0;
              rx_done_o    <= 1'b1;
              rx_data_out  <= shreg;
              parity_err_o <= parity_pend;
              frame_err_o  <= ~rxs;
            end
          end
        end
        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_aux.sv
`default_nettype none
// =============================================================================
// tb_uart_rx_aux : scoreboard bench driving serial frames into uart_rx_aux.
// Rev 1.0
// =============================================================================
module tb_uart_rx_aux;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       s_ticks = 1'b0;
  logic       rx_data_in = 1'b1;
  logic [7:0] rx_data_out;
  logic       rx_done_o;
  logic       parity_err_o;
  logic       frame_err_o;

  uart_rx_aux dut (
    .clock        (clock),
    .reset        (reset),
    .s_ticks      (s_ticks),
    .rx_data_in   (rx_data_in),
    .rx_data_out  (rx_data_out),
    .rx_done_o    (rx_done_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       f;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic stall = 1'b0;

  // Latency reference: ticks counted from the clock the receiver leaves Idle
  int   lat_c0 = 0;
  int   lat_ticks = 0;
  int   lat_done_cyc = -1;
  logic lat_armed = 1'b0;

  initial begin
    int div = 0;
    forever begin
      @(negedge clock);
      if (!stall) begin
        div     = (div + 1) % 4;
        s_ticks = (div == 0);
      end else begin
        s_ticks = 1'b0;
      end
    end
  end

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (lat_armed && cyc >= lat_c0 + 4 && s_ticks) begin
      lat_ticks = lat_ticks + 1;
      if (lat_ticks == 168) begin
        lat_done_cyc = cyc;
        lat_armed    = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (reset && rx_done_o) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got data=%h par=%b frm=%b required no pulse",
                 rx_data_out, parity_err_o, frame_err_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (rx_data_out !== e.d || parity_err_o !== e.p || frame_err_o !== e.f) begin
          errors++;
          $display("FAIL frame got data=%h par=%b frm=%b required data=%h par=%b frm=%b",
                   rx_data_out, parity_err_o, frame_err_o, e.d, e.p, e.f);
        end
        checks++;
        if (cyc != lat_done_cyc) begin
          errors++;
          $display("FAIL latency got done at cycle %0d required cycle %0d", cyc, lat_done_cyc);
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clock);
      if (s_ticks) c++;
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_data_in = b;
    wait_ticks(16);
  endtask

  task automatic start_frame();
    lat_c0       = cyc;
    lat_ticks    = 0;
    lat_done_cyc = -1;
    lat_armed    = 1'b1;
    send_bit(1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    exp_t e;
    e.d = d;
    e.p = p;
    e.f = ~s;
    q.push_back(e);
    start_frame();
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    if (s) begin
      send_bit(1'b1);
    end else begin
      // Low past the mid-bit sample, then high before the re-entered start confirms
      rx_data_in = 1'b0;
      wait_ticks(12);
      rx_data_in = 1'b1;
      wait_ticks(20);
    end
  endtask

  task automatic check_outs(input string name, input logic [7:0] d, input logic p,
                            input logic f, input logic dn);
    checks++;
    if (rx_data_out !== d || parity_err_o !== p || frame_err_o !== f || rx_done_o !== dn) begin
      errors++;
      $display("FAIL %s got data=%h par=%b frm=%b done=%b required data=%h par=%b frm=%b done=%b",
               name, rx_data_out, parity_err_o, frame_err_o, rx_done_o, d, p, f, dn);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired with %0d frames outstanding", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_outs("reset_values", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    wait_ticks(20);

    send_frame(8'hA5, 1'b0, 1'b1);

    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1);
    wait_ticks(8);

    // Short low glitch on the idle line must be rejected
    rx_data_in = 1'b0;
    wait_ticks(5);
    rx_data_in = 1'b1;
    wait_ticks(30);
    check_outs("glitch_hold", 8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1);

    send_frame(8'h81, 1'b1, 1'b1);
    send_frame(8'h81, 1'b0, 1'b0);
    wait_ticks(4);

    // Reset asserted during data bit 4
    start_frame();
    for (int i = 0; i < 4; i++) send_bit(logic'((8'h96 >> i) & 8'h01));
    rx_data_in = 1'b0;
    wait_ticks(8);
    @(negedge clock);
    #1;
    check_outs("pre_reset_outs", 8'h81, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    check_outs("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rx_data_in = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    wait_ticks(20);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL reset_no_done got %0d pending required 0", q.size());
    end
    send_frame(8'h96, 1'b0, 1'b1);

    // Tick stall in the middle of a data bit
    fork
      send_frame(8'h4E, 1'b0, 1'b1);
      begin
        wait_ticks(16 * 4 + 6);
        stall = 1'b1;
        repeat (50) @(posedge clock);
        #1;
        stall = 1'b0;
      end
    join
    wait_ticks(4);

    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      logic       p;
      logic       s;
      d = 8'($urandom);
      p = ($urandom_range(3) == 0);
      s = ($urandom_range(4) != 0);
      send_frame(d, p, s);
      if ($urandom_range(1) == 1) wait_ticks($urandom_range(1, 20));
    end

    begin
      int t = 0;
      while (q.size() != 0 && t < 2000) begin
        @(posedge clock);
        t++;
      end
    end
    wait_ticks(4);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d frames missing required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_aux.md
Name: uart_rx_aux

Overview:
Auxiliary UART receiver: the receive-side counterpart of the auxiliary UART transmitter on the debug/load link of the MIPS board. Oversamples the serial line at 16 s_ticks per bit from the shared baud-tick generator. Deframes start + 8 data (LSB first) + parity + stop. Delivers the byte with a one-clock done strobe and error flags to the debug unit.

Parameters:
N_BITS_DATA, 8, data bits per frame
N_CONT_TICKS, 4, width of tick counter and bit counter
N_BITS_STATE, 5, one-hot state vector width
COUNT_READ_DATA, 16, s_ticks per bit (local constant, not overridable)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
s_ticks  input  1  oversampling strobe, one clock wide, 16 per bit period
rx_data_in  input  1  serial line, asynchronous to clock, idle high
rx_data_out  output  N_BITS_DATA  last received byte, registered
rx_done_o  output  1  one-clock pulse: rx_data_out and flags updated
parity_err_o  output  1  sampled parity bit was 1 (link parity is fixed 0)
frame_err_o  output  1  sampled stop bit was 0

Behaviour:
- Reset (reset=0, async): state=Idle; both synchronizer FFs=1; counters=0; shift reg=0; rx_data_out=0; rx_done_o=0; parity_err_o=0; frame_err_o=0.
- rx_data_in passes through a 2-FF synchronizer (rxs); all decisions use rxs only.
- One-hot states: Idle=00001, Start=00010, Data=00100, Parity=01000, Stop=10000; illegal encoding -> Idle next clock.
- Tick counter advances only on s_ticks while state != Idle; wraps 15->0; cleared on entering Start, Data, Idle.
- Idle: rxs==0 on any clock (independent of s_ticks) -> Start, tick counter=0.
- Start: on s_tick with count==7 (8th tick, mid start bit): rxs==0 -> Data, counter=0, bit counter=0; rxs==1 -> Idle (glitch rejected, no done, flags unchanged).
- Data: on s_tick with count==15: shift rxs into MSB of shift reg (right shift, LSB first on line); bit counter++; after 8th sample -> Parity.
- Parity: on s_tick with count==15: store rxs as pending parity error -> Stop.
- Stop: on s_tick with count==15: -> Idle; next clock rx_done_o=1 for exactly one clock, rx_data_out=shift reg, parity_err_o=pending parity, frame_err_o=~rxs.
- Byte delivered even with errors; flags hold until next rx_done_o.
- Latency: rx_done_o rises 1 clock after the 168th s_tick counted from the Idle->Start transition (8 + 16x10).
- Receiver returns to Idle mid stop bit: next start edge accepted immediately, so back-to-back frames from the transmitter are received without loss.
- s_ticks absent: state and counters hold indefinitely.
- Frame error with line stuck low: after Stop -> Idle, rxs==0 immediately re-enters Start; Start confirm then proceeds as a new frame (break produces repeated frames of 0x00 with frame_err_o=1).
- reset asserted mid-frame: immediate return to reset values, no rx_done_o; first frame after release is received normally.
- Synchronizer adds 2 clocks of input delay; tests allow for this.

Test Plan:
- Single frame 0xA5, parity 0, stop 1, s_ticks every 4 clocks -> one rx_done_o pulse, rx_data_out=0xA5, parity_err_o=0, frame_err_o=0.
- Three back-to-back frames 0x00, 0xFF, 0x3C, no idle gap -> exactly three done pulses with data in order, all flags 0.
- Low glitch of 5 s_ticks on idle line -> returns to Idle, no rx_done_o, outputs unchanged; a following 0x5A frame is received correctly.
- Frame 0x81 with parity bit 1, then frame 0x81 with stop bit 0 -> first: data 0x81, parity_err_o=1, frame_err_o=0; second: data 0x81, parity_err_o=0, frame_err_o=1.
- reset driven low during data bit 4 of frame 0x96 -> outputs return to reset values asynchronously, no done; after release a 0x96 frame is received with flags 0.
- s_ticks stalled 50 clocks mid data bit of frame 0x4E, line held steady -> byte received as 0x4E, done 1 clock after 168th tick.
